// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage types and constants for the RV64 front end.
package instr_fetch_unit_pkg;
  localparam int XLEN        = 64;
  localparam int ILEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0;
  // addi x0,x0,0 -- used downstream when decode needs to insert a bubble
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_pkt_t;
endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Small instruction buffer: DEPTH entries of {pc, instr}, head read combinationally.
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_pkt_t    push_pkt,
  output fetch_pkt_t    head,
  output logic [CW-1:0] count,
  output logic          empty
);
  fetch_pkt_t      mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;

  // flush wins over a same-cycle push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= push_pkt;
  end

  assign head  = mem[rptr];
  assign empty = (count == '0);
endmodule

// File: rtl/instr_fetch_unit.sv
// RV64 fetch stage: PC, credit-limited imem requests, response buffering and redirect drop.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [ILEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc, rsp_pc, redirect_tgt;
  logic [CW-1:0]   outstanding, drop, fifo_count, rsp_dec;
  logic [CW:0]     credits_used;
  logic            req_fire, rsp_keep, pop, fifo_empty;
  fetch_pkt_t      head, push_pkt;

  assign redirect_tgt = redirect_pc & ~64'h3;
  assign rsp_dec      = CW'(imem_rsp_valid);

  // every in-flight fetch reserves a buffer slot, so the FIFO never overflows
  assign credits_used   = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = rst_n && !redirect_valid && (credits_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_keep = imem_rsp_valid && (drop == '0) && !redirect_valid;
  assign push_pkt = '{pc: rsp_pc, instr: imem_rsp_data};
  assign pop      = id_valid && id_ready && !redirect_valid;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rsp_keep),
    .pop      (pop),
    .flush    (redirect_valid),
    .push_pkt (push_pkt),
    .head     (head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  assign id_valid = rst_n && !fifo_empty;
  assign id_instr = id_valid ? head.instr : '0;
  assign id_pc    = id_valid ? head.pc    : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect_valid) begin
      // everything still in flight belongs to the old path
      pc          <= redirect_tgt;
      rsp_pc      <= redirect_tgt;
      outstanding <= outstanding - rsp_dec;
      drop        <= outstanding - rsp_dec;
    end else begin
      if (req_fire) pc     <= pc + XLEN'(INSTR_BYTES);
      if (rsp_keep) rsp_pc <= rsp_pc + XLEN'(INSTR_BYTES);
      outstanding <= outstanding + CW'(req_fire) - rsp_dec;
      if (imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
    end
  end

  a_rsp_credit: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outstanding != '0));
  a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n)
    drop <= outstanding);
endmodule
